bank_scatter_dma: RTL and testbench
===================================

Name: bank_scatter_dma

Overview:
- Stream-to-multibank RAM writer. Takes a valid/ready byte stream and scatters it linearly across NUM_BANKS RAM banks of BANK_DEPTH words each: bank 0 addr 0..BANK_DEPTH-1, then bank 1, and so on.
- Generalised successor of the team's fixed 16-bank loader. Adds start/frame control, backpressure, optional wrap mode, a frame-done pulse and overflow detection.
- Sits between the input capture path and the bank RAM array.

Parameters:
- DATA_W, 8: stream and RAM data width.
- NUM_BANKS, 16: number of RAM banks, >=2.
- BANK_DEPTH, 940: words per bank, >=2.
- ADDR_W, 10: RAM address width; must satisfy 2^ADDR_W >= BANK_DEPTH.
- SEL_W, 4: bank select width; must satisfy 2^SEL_W >= NUM_BANKS.
- WRAP_MODE, 0: 0 = stop when all banks are full; 1 = wrap to bank 0 addr 0 and continue.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle pulse; begins a new frame from bank 0 addr 0.
- enable, input, 1: global gate; 0 stalls acceptance without losing position.
- s_valid, input, 1: stream data valid.
- s_data, input, DATA_W: stream data.
- s_ready, output, 1: block can accept a beat.
- ram_wr_en, output, 1: RAM write strobe, registered.
- ram_addr, output, ADDR_W: RAM word address, registered.
- ram_sel, output, SEL_W: bank index, registered.
- ram_bank_we, output, NUM_BANKS: one-hot per-bank write enable, equal to ram_wr_en decoded by ram_sel.
- ram_data, output, DATA_W: RAM write data, registered.
- busy, output, 1: state == RUN.
- frame_done, output, 1: one-cycle pulse when the last word of the last bank is written.
- overflow, output, 1: sticky; a beat was offered while FULL.
- word_count, output, ADDR_W+SEL_W: beats accepted in the current frame; saturates at NUM_BANKS*BANK_DEPTH; in wrap mode, resets on wrap.

Behaviour:
- Reset values:
  - state = IDLE; internal bank = 0, addr = 0.
  - ram_wr_en = 0, ram_addr = 0, ram_sel = 0, ram_data = 0, ram_bank_we = 0.
  - frame_done = 0, overflow = 0, word_count = 0.
  - rst has priority over every other input, including mid-frame; there is no partial write after a reset cycle.
- States: IDLE, RUN, FULL.
- s_ready = (state == RUN) && enable && !start (combinational).
- accept = s_valid && s_ready.
- Latency: exactly 1 cycle. An accepted beat in cycle N gives ram_wr_en = 1 in cycle N+1, with ram_addr/ram_sel = position at acceptance and ram_data = s_data. ram_wr_en = 0 in every cycle not following an accept.
- Position advance on accept:
  - If addr < BANK_DEPTH-1: addr+1.
  - Otherwise: addr = 0 and bank+1.
  - If bank == NUM_BANKS-1 and addr == BANK_DEPTH-1, the last slot was written:
    - WRAP_MODE=0: go to FULL; frame_done = 1 in cycle N+1, coincident with the last write.
    - WRAP_MODE=1: bank = 0, addr = 0, stay in RUN; frame_done pulses the same way; word_count resets to 0.
  - Comparisons are equality against the parameter minus 1. No power-of-two assumption; addresses never exceed BANK_DEPTH-1.
- start:
  - Any state goes to RUN with bank = 0, addr = 0, word_count = 0; overflow is cleared.
  - start in RUN aborts the current frame (restart). Since s_ready is low during start, no beat is accepted in that cycle.
  - A write registered from the previous cycle still appears normally.
- IDLE: s_ready = 0; s_valid is ignored and overflow is not set.
- FULL: s_ready = 0; s_valid = 1 sets overflow (sticky until start or rst); no RAM write occurs.
- enable = 0 in RUN: no accept; position and word_count hold.
- busy = 1 only in RUN.

Test Plan:
- Params NUM_BANKS=4, BANK_DEPTH=5, WRAP_MODE=0. rst, start, 20 back-to-back beats 0x00..0x13 → writes (sel, addr) = (0,0)..(0,4),(1,0)..(3,4), each 1 cycle after accept. frame_done pulses with the write of 0x13 at (3,4). state = FULL, s_ready = 0, word_count = 20.
- Same config after FULL, assert s_valid 3 cycles → no ram_wr_en, overflow = 1. Pulse start → overflow = 0, busy = 1, next beat written at (0,0).
- Mid-frame backpressure: drop enable for 4 cycles after beat 7 → s_ready = 0, no writes. On re-enable, beat 8 is written at (1,3) with no gap or skip in addresses.
- WRAP_MODE=1, 23 beats → beat 20 written at (0,0), frame_done pulses with beat 19, busy stays 1, word_count = 3 at the end.
- Abort: start pulsed after 7 beats while s_valid = 1 → no accept that cycle; the next accepted beat is written at (0,0) and word_count restarts from 0.
- rst asserted mid-frame in the cycle after an accept → next cycle ram_wr_en = 0, all outputs at reset values, state = IDLE, s_ready = 0.

Source files
------------

// File: rtl/bank_scatter_dma.sv
`default_nettype none
// ============================================================================
// Module      : bank_scatter_dma
// Description : Scatters a valid/ready stream linearly across NUM_BANKS RAM
//               banks, with start/frame control, stall, wrap and overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module bank_scatter_dma #(
    parameter int DATA_W     = 8,
    parameter int NUM_BANKS  = 16,
    parameter int BANK_DEPTH = 940,
    parameter int ADDR_W     = 10,
    parameter int SEL_W      = 4,
    parameter int WRAP_MODE  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     enable,
    input  logic                     s_valid,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     s_ready,
    output logic                     ram_wr_en,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [SEL_W-1:0]         ram_sel,
    output logic [NUM_BANKS-1:0]     ram_bank_we,
    output logic [DATA_W-1:0]        ram_data,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overflow,
    output logic [ADDR_W+SEL_W-1:0]  word_count
);

    localparam int c_cnt_w = ADDR_W + SEL_W;
    localparam logic [ADDR_W-1:0]  c_last_addr = ADDR_W'(BANK_DEPTH - 1);
    localparam logic [SEL_W-1:0]   c_last_bank = SEL_W'(NUM_BANKS - 1);
    localparam logic [c_cnt_w-1:0] c_total     = c_cnt_w'(NUM_BANKS * BANK_DEPTH);
    localparam logic [ADDR_W-1:0]  c_addr_one  = ADDR_W'(1);
    localparam logic [SEL_W-1:0]   c_sel_one   = SEL_W'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t               r_state;
    logic [SEL_W-1:0]     r_bank;
    logic [ADDR_W-1:0]    r_addr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_wr_en;
    logic [ADDR_W-1:0]    r_ram_addr;
    logic [SEL_W-1:0]     r_ram_sel;
    logic [DATA_W-1:0]    r_ram_data;
    logic                 r_frame_done;
    logic                 r_overflow;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_last_addr;
    logic                 w_last_slot;
    logic [NUM_BANKS-1:0] w_bank_we;

    assign w_ready     = (r_state == ST_RUN) && enable && !start;
    assign w_accept    = s_valid && w_ready;
    assign w_last_addr = (r_addr == c_last_addr);
    assign w_last_slot = w_last_addr && (r_bank == c_last_bank);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_bank       <= '0;
            r_addr       <= '0;
            r_count      <= '0;
            r_wr_en      <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_sel    <= '0;
            r_ram_data   <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            if (start) begin
                r_state    <= ST_RUN;
                r_bank     <= '0;
                r_addr     <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_accept) begin
                            r_wr_en    <= 1'b1;
                            r_ram_addr <= r_addr;
                            r_ram_sel  <= r_bank;
                            r_ram_data <= s_data;
                            if (w_last_slot) begin
                                // Last slot of the array: the pulse lines up with its write
                                r_frame_done <= 1'b1;
                                r_addr       <= '0;
                                r_bank       <= '0;
                                if (WRAP_MODE != 0) begin
                                    r_count <= '0;
                                end else begin
                                    r_state <= ST_FULL;
                                    r_count <= r_count + c_cnt_one;
                                end
                            end else begin
                                if (w_last_addr) begin
                                    r_addr <= '0;
                                    r_bank <= r_bank + c_sel_one;
                                end else begin
                                    r_addr <= r_addr + c_addr_one;
                                end
                                if (r_count != c_total) begin
                                    r_count <= r_count + c_cnt_one;
                                end
                            end
                        end
                    end
                    ST_FULL: begin
                        if (s_valid) begin
                            r_overflow <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank_we
            assign w_bank_we[i] = r_wr_en && (r_ram_sel == SEL_W'(i));
        end
    endgenerate

    assign s_ready     = w_ready;
    assign ram_wr_en   = r_wr_en;
    assign ram_addr    = r_ram_addr;
    assign ram_sel     = r_ram_sel;
    assign ram_bank_we = w_bank_we;
    assign ram_data    = r_ram_data;
    assign busy        = (r_state == ST_RUN);
    assign frame_done  = r_frame_done;
    assign overflow    = r_overflow;
    assign word_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bank_scatter_dma.sv
`default_nettype none
// ============================================================================
// Module      : tb_bank_scatter_dma
// Description : Bench for bank_scatter_dma; stop and wrap instances side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bank_scatter_dma;

    localparam int NB    = 4;
    localparam int DEPTH = 5;
    localparam int TOTAL = NB * DEPTH;

    logic       clk = 1'b0;
    logic       rst, start, enable, s_valid;
    logic [7:0] s_data;

    logic       rdy[2], wr[2], bsy[2], done[2], ovf[2];
    logic [2:0] addr[2];
    logic [1:0] sel[2];
    logic [3:0] bwe[2];
    logic [7:0] data[2];
    logic [4:0] wc[2];

    // Instance 0 stops when full, instance 1 wraps
    bank_scatter_dma #(.DATA_W(8), .NUM_BANKS(NB), .BANK_DEPTH(DEPTH), .ADDR_W(3), .SEL_W(2), .WRAP_MODE(0)) u_stop (
        .clk(clk), .rst(rst), .start(start), .enable(enable), .s_valid(s_valid), .s_data(s_data),
        .s_ready(rdy[0]), .ram_wr_en(wr[0]), .ram_addr(addr[0]), .ram_sel(sel[0]), .ram_bank_we(bwe[0]),
        .ram_data(data[0]), .busy(bsy[0]), .frame_done(done[0]), .overflow(ovf[0]), .word_count(wc[0]));

    bank_scatter_dma #(.DATA_W(8), .NUM_BANKS(NB), .BANK_DEPTH(DEPTH), .ADDR_W(3), .SEL_W(2), .WRAP_MODE(1)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .enable(enable), .s_valid(s_valid), .s_data(s_data),
        .s_ready(rdy[1]), .ram_wr_en(wr[1]), .ram_addr(addr[1]), .ram_sel(sel[1]), .ram_bank_we(bwe[1]),
        .ram_data(data[1]), .busy(bsy[1]), .frame_done(done[1]), .overflow(ovf[1]), .word_count(wc[1]));

    always #5 clk = ~clk;

    // Reference: mode 0 idle, 1 run, 2 full; position is a flat beat index
    int m_mode[2], m_idx[2], e_wr[2], e_sel[2], e_addr[2], e_data[2], e_done[2], e_ovf[2];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=0x%0h expected=0x%0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_step(input int k, input bit r, input bit st, input bit v,
                              input logic [7:0] d, input bit ready_exp);
        if (r) begin
            m_mode[k] = 0; m_idx[k] = 0; e_wr[k] = 0; e_sel[k] = 0;
            e_addr[k] = 0; e_data[k] = 0; e_done[k] = 0; e_ovf[k] = 0;
        end else begin
            e_wr[k]   = 0;
            e_done[k] = 0;
            if (st) begin
                m_mode[k] = 1; m_idx[k] = 0; e_ovf[k] = 0;
            end else if (m_mode[k] == 1 && v && ready_exp) begin
                e_wr[k]   = 1;
                e_sel[k]  = m_idx[k] / DEPTH;
                e_addr[k] = m_idx[k] % DEPTH;
                e_data[k] = int'(d);
                m_idx[k]++;
                if (m_idx[k] == TOTAL) begin
                    e_done[k] = 1;
                    if (k == 1) m_idx[k] = 0;
                    else        m_mode[k] = 2;
                end
            end else if (m_mode[k] == 2 && v) begin
                e_ovf[k] = 1;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit st, input bit en, input bit v, input logic [7:0] d);
        bit er[2];
        rst = r; start = st; enable = en; s_valid = v; s_data = d;
        #1;
        for (int k = 0; k < 2; k++) begin
            er[k] = (m_mode[k] == 1) && en && !st;
            if (!r) check("s_ready", k, 32'(rdy[k]), 32'(er[k]));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            model_step(k, r, st, v, d, er[k]);
            check("ram_wr_en",   k, 32'(wr[k]),   32'(e_wr[k]));
            check("ram_sel",     k, 32'(sel[k]),  32'(e_sel[k]));
            check("ram_addr",    k, 32'(addr[k]), 32'(e_addr[k]));
            check("ram_data",    k, 32'(data[k]), 32'(e_data[k]));
            check("ram_bank_we", k, 32'(bwe[k]),  e_wr[k] != 0 ? (32'd1 << e_sel[k]) : 32'd0);
            check("busy",        k, 32'(bsy[k]),  32'(m_mode[k] == 1));
            check("frame_done",  k, 32'(done[k]), 32'(e_done[k]));
            check("overflow",    k, 32'(ovf[k]),  32'(e_ovf[k]));
            check("word_count",  k, 32'(wc[k]),   32'(m_idx[k]));
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_idx[k] = 0; e_wr[k] = 0; e_sel[k] = 0;
            e_addr[k] = 0; e_data[k] = 0; e_done[k] = 0; e_ovf[k] = 0;
        end

        // Reset, then IDLE ignores s_valid
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);

        // Full frame of 20 back-to-back beats 0x00..0x13
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < TOTAL; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'(i));
        check("full_wc", 0, 32'(wc[0]), 32'd20);
        check("full_busy", 0, 32'(bsy[0]), 32'd0);

        // Offers while FULL set overflow; start clears it
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom));
        check("ovf_set", 0, 32'(ovf[0]), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        check("ovf_clr", 0, 32'(ovf[0]), 32'd0);

        // Beats 0..7, enable low for 4 cycles, then 15 more beats (23 total)
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom));
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom));
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom));
        check("beat8_sel", 0, 32'(sel[0]), 32'd1);
        check("beat8_addr", 0, 32'(addr[0]), 32'd3);
        for (int i = 9; i < 23; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom));
        check("wrap_wc", 1, 32'(wc[1]), 32'd3);
        check("wrap_busy", 1, 32'(bsy[1]), 32'd1);

        // Abort: start with s_valid high after 7 beats
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom));
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'hEE);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom));
        check("abort_addr", 0, 32'(addr[0]), 32'd0);
        check("abort_wc", 0, 32'(wc[0]), 32'd1);

        // Randomised traffic with occasional restarts
        for (int i = 0; i < 200; i++)
            cyc(1'b0, $urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0,
                $urandom_range(0, 3) != 0, 8'($urandom));

        // Reset in the cycle after an accept
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h77);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h33);
        check("post_rst_ready", 0, 32'(rdy[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
